// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        MUL = 1'b1
    } pipe_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MUL_LAT_MIN = 2;
    localparam int         MUL_LAT_MAX = 16;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use comparator between the EX load and ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);

    // A load into r0 never creates a dependency.
    assign o_load_use = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule : load_use_detect

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush controller for the 5-stage pipeline with perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_mul_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             mul_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Out-of-range latencies are clamped so the 4-bit down-counter stays valid.
    localparam int         c_MUL_LAT_EFF = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN :
                                           (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;
    localparam logic [3:0] c_MUL_INIT    = 4'(c_MUL_LAT_EFF - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic [3:0]       r_mul_cnt;
    logic [3:0]       w_mul_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;

    load_use_detect u_load_use_detect (
        .i_ex_memread (ex_memread_i),
        .i_ex_rt      (ex_rt_i),
        .i_id_rs      (id_rs_i),
        .i_id_rt      (id_rt_i),
        .i_id_uses_rt (id_uses_rt_i),
        .o_load_use   (w_lu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= RUN;
            r_mul_cnt <= 4'd0;
        end else begin
            r_state   <= w_next_state;
            r_mul_cnt <= w_mul_cnt_next;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_mul_cnt_next = r_mul_cnt;
        if (mem_branch_taken_i) begin
            w_next_state   = RUN;
            w_mul_cnt_next = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    // A multiply held behind a load-use stall is retried next cycle.
                    if (id_mul_i && !w_lu) begin
                        w_next_state   = MUL;
                        w_mul_cnt_next = c_MUL_INIT;
                    end
                end
                MUL: begin
                    w_mul_cnt_next = r_mul_cnt - 4'd1;
                    if (r_mul_cnt == 4'd1) begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    w_next_state   = RUN;
                    w_mul_cnt_next = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
        end else if (mem_branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (r_state == MUL) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_flush_o = 1'b1;
        end else if (w_lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_flush_o  = 1'b1;
        end
    end

    assign mul_busy_o = (r_state == MUL) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write_o && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (mem_branch_taken_i && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule : pipe_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl (MUL_LAT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             id_mul_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             mem_branch_taken_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_write_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             mul_busy_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .id_rs_i            (id_rs_i),
        .id_rt_i            (id_rt_i),
        .id_uses_rt_i       (id_uses_rt_i),
        .id_mul_i           (id_mul_i),
        .ex_memread_i       (ex_memread_i),
        .ex_rt_i            (ex_rt_i),
        .mem_branch_taken_i (mem_branch_taken_i),
        .pc_write_o         (pc_write_o),
        .ifid_write_o       (ifid_write_o),
        .ifid_flush_o       (ifid_flush_o),
        .idex_write_o       (idex_write_o),
        .idex_flush_o       (idex_flush_o),
        .exmem_flush_o      (exmem_flush_o),
        .mul_busy_o         (mul_busy_o),
        .stall_cnt_o        (stall_cnt_o),
        .flush_cnt_o        (flush_cnt_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_rs_i            = 5'd0;
        id_rt_i            = 5'd0;
        id_uses_rt_i       = 1'b0;
        id_mul_i           = 1'b0;
        ex_memread_i       = 1'b0;
        ex_rt_i            = 5'd0;
        mem_branch_taken_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        #3;
        n_checks++;
        if ({pc_write_o, ifid_write_o, idex_write_o, mul_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_forced_enables: got %b want 0000", {pc_write_o, ifid_write_o, idex_write_o, mul_busy_o});
        end
        cycle();
        rst_i = 1'b0;
        #3;
        n_checks++;
        if ({pc_write_o, ifid_write_o, idex_write_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_idle_enables: got %b want 111", {pc_write_o, ifid_write_o, idex_write_o});
        end
        n_checks++;
        if ({ifid_flush_o, idex_flush_o, exmem_flush_o, mul_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle_flushes: got %b want 0000", {ifid_flush_o, idex_flush_o, exmem_flush_o, mul_busy_o});
        end
        n_checks++;
        if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        cycle();
        ex_memread_i = 1'b1;
        ex_rt_i      = 5'd8;
        id_rs_i      = 5'd8;
        #3;
        n_checks++;
        if ({pc_write_o, ifid_write_o, idex_flush_o, idex_write_o} !== 4'b0011) begin
            n_fail++;
            $display("FAIL lu_outputs: got pc,ifid_w,idex_fl,idex_w=%b want 0011", {pc_write_o, ifid_write_o, idex_flush_o, idex_write_o});
        end
        cycle();
        idle();
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1 || stall_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL lu_after: got pc_write=%b stall=%0d want 1 1", pc_write_o, stall_cnt_o);
        end
    endtask

    task automatic test_rt_hazard();
        cycle();
        ex_memread_i = 1'b1;
        ex_rt_i      = 5'd9;
        id_rt_i      = 5'd9;
        id_rs_i      = 5'd3;
        id_uses_rt_i = 1'b0;
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_unused: got pc_write=%b want 1", pc_write_o);
        end
        cycle();
        id_uses_rt_i = 1'b1;
        #3;
        n_checks++;
        if (pc_write_o !== 1'b0 || idex_flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_used: got pc_write=%b idex_flush=%b want 0 1", pc_write_o, idex_flush_o);
        end
        cycle();
        id_uses_rt_i = 1'b0;
        ex_rt_i      = 5'd0;
        id_rs_i      = 5'd0;
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_load: got pc_write=%b want 1", pc_write_o);
        end
        cycle();
        idle();
        #3;
        n_checks++;
        if (stall_cnt_o !== 4'd2) begin
            n_fail++;
            $display("FAIL rt_stall_count: got %0d want 2", stall_cnt_o);
        end
    endtask

    task automatic test_multiply();
        do_reset();
        id_mul_i = 1'b1;
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1 || mul_busy_o !== 1'b0 || idex_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_issue: got pc=%b busy=%b idex_w=%b want 1 0 1", pc_write_o, mul_busy_o, idex_write_o);
        end
        cycle();
        id_mul_i = 1'b0;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            #3;
            n_checks++;
            if ({mul_busy_o, idex_write_o, exmem_flush_o, pc_write_o} !== 4'b1010) begin
                n_fail++;
                $display("FAIL mul_cycle%0d: got busy,idex_w,exmem_fl,pc=%b want 1010", i, {mul_busy_o, idex_write_o, exmem_flush_o, pc_write_o});
            end
            cycle();
        end
        #3;
        n_checks++;
        if (mul_busy_o !== 1'b0 || pc_write_o !== 1'b1 || stall_cnt_o !== 4'd3) begin
            n_fail++;
            $display("FAIL mul_done: got busy=%b pc=%b stall=%0d want 0 1 3", mul_busy_o, pc_write_o, stall_cnt_o);
        end
    endtask

    task automatic test_branch_override();
        do_reset();
        id_mul_i = 1'b1;
        cycle();
        id_mul_i = 1'b0;
        cycle();
        mem_branch_taken_i = 1'b1;
        #3;
        n_checks++;
        if ({ifid_flush_o, idex_flush_o, exmem_flush_o, pc_write_o, ifid_write_o, idex_write_o} !== 6'b111111) begin
            n_fail++;
            $display("FAIL br_outputs: got %b want 111111", {ifid_flush_o, idex_flush_o, exmem_flush_o, pc_write_o, ifid_write_o, idex_write_o});
        end
        cycle();
        mem_branch_taken_i = 1'b0;
        #3;
        n_checks++;
        if (mul_busy_o !== 1'b0 || pc_write_o !== 1'b1 || flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL br_after: got busy=%b pc=%b flush=%0d stall=%0d want 0 1 1 1", mul_busy_o, pc_write_o, flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_branch_and_lu();
        cycle();
        ex_memread_i       = 1'b1;
        ex_rt_i            = 5'd8;
        id_rs_i            = 5'd8;
        mem_branch_taken_i = 1'b1;
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1 || ifid_flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL br_lu_outputs: got pc=%b ifid_flush=%b want 1 1", pc_write_o, ifid_flush_o);
        end
        cycle();
        idle();
        #3;
        n_checks++;
        if (stall_cnt_o !== 4'd1 || flush_cnt_o !== 4'd2) begin
            n_fail++;
            $display("FAIL br_lu_counters: got stall=%0d flush=%0d want 1 2", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_memread_i = 1'b1;
        ex_rt_i      = 5'd12;
        id_rt_i      = 5'd12;
        id_uses_rt_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
        end
        #3;
        n_checks++;
        if (stall_cnt_o !== 4'd15 || pc_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_saturate: got stall=%0d pc=%b want 15 0", stall_cnt_o, pc_write_o);
        end
        idle();
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        id_mul_i = 1'b1;
        cycle();
        id_mul_i = 1'b0;
        #3;
        n_checks++;
        if (mul_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mul_entered: got busy=%b want 1", mul_busy_o);
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (mul_busy_o !== 1'b0 || pc_write_o !== 1'b0 || exmem_flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mul_forced: got busy=%b pc=%b exmem_fl=%b want 0 0 0", mul_busy_o, pc_write_o, exmem_flush_o);
        end
        cycle();
        rst_i = 1'b0;
        #3;
        n_checks++;
        if ({pc_write_o, ifid_write_o, idex_write_o, exmem_flush_o, mul_busy_o} !== 5'b11100 || stall_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mul_resume: got %b stall=%0d want 11100 0", {pc_write_o, ifid_write_o, idex_write_o, exmem_flush_o, mul_busy_o}, stall_cnt_o);
        end
        cycle();
        #3;
        n_checks++;
        if (pc_write_o !== 1'b1 || mul_busy_o !== 1'b0 || stall_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mul_no_residual: got pc=%b busy=%b stall=%0d want 1 0 0", pc_write_o, mul_busy_o, stall_cnt_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_rt_hazard();
        test_multiply();
        test_branch_override();
        test_branch_and_lu();
        test_saturation();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions:
- load-use stalls;
- multi-cycle multiply occupancy of EX;
- taken-branch flushes.

It also keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- MUL_LAT, 4, total EX-stage cycles of a multiply; legal range 2..16
- CNT_W, 16, width of the performance counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads rt as a source
- id_mul_i  in  1  the ID instruction is a multiply
- ex_memread_i  in  1  the instruction in EX is a load
- ex_rt_i  in  5  destination register of the EX load
- mem_branch_taken_i  in  1  branch in MEM resolved taken
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID clear to NOP
- idex_write_o  out  1  ID/EX load enable (0 = hold)
- idex_flush_o  out  1  ID/EX load all-zero control (bubble)
- exmem_flush_o  out  1  EX/MEM load all-zero control (bubble)
- mul_busy_o  out  1  FSM is in MUL
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (saturating)
- flush_cnt_o  out  CNT_W  taken-branch flush events (saturating)

## Operation
- FSM states are RUN and MUL. A down-counter mul_cnt is 4 bits wide.
- Load-use hazard (LU) condition, all of:
  - ex_memread_i=1;
  - ex_rt_i≠0;
  - ex_rt_i==id_rs_i, or (id_uses_rt_i=1 and ex_rt_i==id_rt_i).
- Default outputs in RUN: pc_write=1, ifid_write=1, idex_write=1, all flushes 0.
- Branch override: mem_branch_taken_i=1 overrides every other condition, in either state.
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_flush=1, exmem_flush=1.
  - Next state is RUN; mul_cnt is cleared.
  - flush_cnt increments.
- RUN with LU (no branch):
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - State stays RUN.
  - A pending id_mul_i is ignored this cycle and re-evaluated next cycle, because ID is held.
- RUN with id_mul_i, no LU, no branch:
  - Outputs are the defaults, so the multiply enters EX.
  - Next state is MUL with mul_cnt=MUL_LAT-1.
- MUL (no branch):
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1.
  - mul_cnt decrements each cycle.
  - When mul_cnt==1, next state is RUN.
  - MUL therefore lasts exactly MUL_LAT-1 cycles.
- LU detection is masked in MUL.
- stall_cnt increments in every cycle where pc_write_o=0. Both counters hold at all-ones.
- mul_busy_o=1 exactly when state=MUL.

## Timing
- All control outputs are combinational from the current state and inputs. They are valid in the same cycle and take effect at the next edge.
- Counters and FSM state are registered. Counter values are visible the cycle after the event.
- While rst_i=1, outputs are forced regardless of inputs:
  - write enables 0, flushes 0, mul_busy_o 0.
- Reset values after the edge: state RUN, mul_cnt 0, stall_cnt_o 0, flush_cnt_o 0.
- Load-use costs exactly 1 stall cycle.
- A multiply costs MUL_LAT-1 stall cycles.
- A taken branch costs 3 flushed slots and 0 stall cycles.
- Branch and LU in the same cycle: branch wins, and stall_cnt does not increment.
- Reset asserted mid-MUL: on the reset edge the FSM is in RUN with mul_cnt=0, and no residual stall follows.
- MUL_LAT=2: MUL lasts 1 cycle.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, MUL};
  - REG_ZERO (5'd0);
  - MUL_LAT legal bounds.
- Sub-module load_use_detect: purely combinational comparator producing LU from the rs/rt/memread inputs. It is reused later by the forwarding unit.

## Test plan
- Reset, then idle inputs → all write enables 1, flushes 0, counters 0.
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for 1 cycle → pc_write_o=0, ifid_write_o=0, idex_flush_o=1 for that cycle; stall_cnt_o=1 afterwards.
- rt hazard case:
  - ex_rt_i=9, id_rt_i=9, id_uses_rt_i=0 → no stall;
  - same registers with id_uses_rt_i=1 → stall;
  - ex_rt_i=0 matching id_rs_i=0 → no stall.
- Multiply, MUL_LAT=4: id_mul_i=1 in RUN → mul_busy_o=1 for exactly 3 cycles with idex_write_o=0 and exmem_flush_o=1; stall_cnt_o=3 afterwards.
- Branch override: mem_branch_taken_i=1 on the 2nd MUL cycle → all three flushes 1, mul_busy_o=0 next cycle, flush_cnt_o=1.
- Saturation with CNT_W=4: hold an LU for 20 cycles → stall_cnt_o stops at 15.
- Reset mid-MUL: assert rst_i in the 1st MUL cycle, then deassert → outputs resume the RUN defaults immediately.
